multicycle_control_unit: RTL and testbench

//  Registered, handshaked successor of the single-cycle MIPS decoder. Decodes opCode/func into datapath controls.

---
 rtl/multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Registered, handshaked MIPS control decoder with a divide-latency interlock.
// Optional DIV_DONE_EN adds a div_done input that ends the divide early.
module multicycle_control_unit #(
    parameter int ALUOP_W     = 4,
    parameter int DIV_LATENCY = 32
) (
    input  logic               main_clock,
    input  logic               reset,
    input  logic               inst_valid,
    input  logic [5:0]         opCode,
    input  logic [5:0]         func,
`ifdef DIV_DONE_EN
    input  logic               div_done,
`endif
    output logic               inst_ready,
    output logic               stall,
    output logic               ctrl_valid,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               ALUsrc,
    output logic               Rtype,
    output logic               regDst,
    output logic               branch,
    output logic               j,
    output logic               jr,
    output logic               memRead,
    output logic               memToReg,
    output logic               memWrite,
    output logic               regWrite,
    output logic               shmt,
    output logic               mohi,
    output logic               molo,
    output logic               illegal,
    output logic               div_start,
    output logic               div_busy
);

    localparam int CNT_W = $clog2(DIV_LATENCY + 1);

    typedef struct packed {
        logic [ALUOP_W-1:0] aluOp;
        logic               aluSrc;
        logic               rType;
        logic               regDst;
        logic               branch;
        logic               j;
        logic               jr;
        logic               memRead;
        logic               memToReg;
        logic               memWrite;
        logic               regWrite;
        logic               shmt;
        logic               mohi;
        logic               molo;
        logic               illegal;
        logic               divStart;
    } ctrl_t;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [ALUOP_W-1:0] aluCode(input logic [3:0] code);
        return ALUOP_W'(code);
    endfunction

    ctrl_t            dec, ctrlReg;
    logic             ctrlValidReg;
    logic             isDiv, isMfhi, isMflo;
    logic             accept;
    logic             earlyDone;
    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;

`ifdef DIV_DONE_EN
    assign earlyDone = div_done;
`else
    assign earlyDone = 1'b0;
`endif

    always_comb begin
        dec    = '0;
        isDiv  = 1'b0;
        isMfhi = 1'b0;
        isMflo = 1'b0;
        case (opCode)
            6'h00: begin
                dec.rType    = 1'b1;
                dec.regDst   = 1'b1;
                dec.regWrite = 1'b1;
                case (func)
                    6'h20: dec.aluOp = aluCode(4'h0);
                    6'h22: dec.aluOp = aluCode(4'h1);
                    6'h24: dec.aluOp = aluCode(4'h4);
                    6'h25: dec.aluOp = aluCode(4'h5);
                    6'h26: dec.aluOp = aluCode(4'h6);
                    6'h04: dec.aluOp = aluCode(4'h9);
                    6'h00: begin
                        dec.aluOp = aluCode(4'h9);
                        dec.shmt  = 1'b1;
                    end
                    6'h06: dec.aluOp = aluCode(4'hA);
                    6'h07: dec.aluOp = aluCode(4'hB);
                    6'h1A: begin
                        dec.aluOp    = aluCode(4'h3);
                        dec.divStart = 1'b1;
                        dec.regWrite = 1'b0;
                        isDiv        = 1'b1;
                    end
                    6'h10: begin
                        dec.aluOp = aluCode(4'hF);
                        dec.mohi  = 1'b1;
                        isMfhi    = 1'b1;
                    end
                    6'h12: begin
                        dec.aluOp = aluCode(4'hF);
                        dec.molo  = 1'b1;
                        isMflo    = 1'b1;
                    end
                    6'h08: begin
                        dec.aluOp    = aluCode(4'hF);
                        dec.jr       = 1'b1;
                        dec.regWrite = 1'b0;
                    end
                    default: begin
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            6'h08: begin
                dec.aluOp    = aluCode(4'hC);
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            6'h0A: begin
                dec.aluOp    = aluCode(4'h2);
                dec.aluSrc   = 1'b1;
                dec.regWrite = 1'b1;
            end
            6'h23: begin
                dec.aluOp    = aluCode(4'h0);
                dec.aluSrc   = 1'b1;
                dec.memRead  = 1'b1;
                dec.memToReg = 1'b1;
                dec.regWrite = 1'b1;
            end
            6'h2B: begin
                dec.aluOp    = aluCode(4'h0);
                dec.aluSrc   = 1'b1;
                dec.memWrite = 1'b1;
            end
            6'h05: begin
                dec.aluOp  = aluCode(4'h7);
                dec.aluSrc = 1'b1;
                dec.branch = 1'b1;
            end
            6'h02: begin
                dec.aluOp = aluCode(4'hF);
                dec.j     = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Only instructions touching HI/LO wait on the divider; everything else flows.
    assign div_busy   = (state == BUSY);
    assign inst_ready = ~(div_busy & (isDiv | isMfhi | isMflo));
    assign stall      = inst_valid & ~inst_ready;
    assign accept     = inst_valid & inst_ready;

    always_ff @(posedge main_clock) begin
        if (reset) begin
            ctrlReg      <= '0;
            ctrlValidReg <= 1'b0;
        end else begin
            ctrlReg      <= accept ? dec : '0;
            ctrlValidReg <= accept;
        end
    end

    always_ff @(posedge main_clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Counter holds the remaining busy cycles including the current one.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (accept && isDiv) begin
                    stateNext = BUSY;
                    cntNext   = CNT_W'(DIV_LATENCY);
                end
            end
            BUSY: begin
                if (earlyDone || cnt <= CNT_W'(1)) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    assign ctrl_valid = ctrlValidReg;
    assign ALUop      = ctrlReg.aluOp;
    assign ALUsrc     = ctrlReg.aluSrc;
    assign Rtype      = ctrlReg.rType;
    assign regDst     = ctrlReg.regDst;
    assign branch     = ctrlReg.branch;
    assign j          = ctrlReg.j;
    assign jr         = ctrlReg.jr;
    assign memRead    = ctrlReg.memRead;
    assign memToReg   = ctrlReg.memToReg;
    assign memWrite   = ctrlReg.memWrite;
    assign regWrite   = ctrlReg.regWrite;
    assign shmt       = ctrlReg.shmt;
    assign mohi       = ctrlReg.mohi;
    assign molo       = ctrlReg.molo;
    assign illegal    = ctrlReg.illegal;
    assign div_start  = ctrlReg.divStart;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed and random instruction streams
// checked against a cycle-indexed reference model of decode and divide interlock.
module tb_multicycle_control_unit;

    localparam int LAT = 4;
`ifdef DIV_DONE_EN
    localparam bit HAS_DONE = 1'b1;
`else
    localparam bit HAS_DONE = 1'b0;
`endif

    logic       main_clock = 1'b0;
    logic       reset = 1'b1;
    logic       inst_valid = 1'b0;
    logic [5:0] opCode = '0;
    logic [5:0] func = '0;
    logic       divDone = 1'b0;
    logic       inst_ready, stall, ctrl_valid;
    logic [3:0] ALUop;
    logic       ALUsrc, Rtype, regDst, branch, j, jr, memRead, memToReg, memWrite;
    logic       regWrite, shmt, mohi, molo, illegal, div_start, div_busy;
    logic [18:0] obsCtrl;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busyStart = 1;
    int busyEnd = 0;

    multicycle_control_unit #(.ALUOP_W(4), .DIV_LATENCY(LAT)) dut (
        .main_clock(main_clock), .reset(reset), .inst_valid(inst_valid),
        .opCode(opCode), .func(func),
`ifdef DIV_DONE_EN
        .div_done(divDone),
`endif
        .inst_ready(inst_ready), .stall(stall), .ctrl_valid(ctrl_valid),
        .ALUop(ALUop), .ALUsrc(ALUsrc), .Rtype(Rtype), .regDst(regDst),
        .branch(branch), .j(j), .jr(jr), .memRead(memRead), .memToReg(memToReg),
        .memWrite(memWrite), .regWrite(regWrite), .shmt(shmt), .mohi(mohi),
        .molo(molo), .illegal(illegal), .div_start(div_start), .div_busy(div_busy)
    );

    always #5 main_clock = ~main_clock;

    assign obsCtrl = {ALUop, ALUsrc, Rtype, regDst, branch, j, jr, memRead, memToReg,
                      memWrite, regWrite, shmt, mohi, molo, illegal, div_start};

    // Flag bit positions inside obsCtrl
    localparam logic [18:0] DS = 19'h1 << 0,  IL = 19'h1 << 1,  ML = 19'h1 << 2;
    localparam logic [18:0] MH = 19'h1 << 3,  SH = 19'h1 << 4,  RW = 19'h1 << 5;
    localparam logic [18:0] MW = 19'h1 << 6,  MT = 19'h1 << 7,  MR = 19'h1 << 8;
    localparam logic [18:0] JR = 19'h1 << 9,  JJ = 19'h1 << 10, BR = 19'h1 << 11;
    localparam logic [18:0] RD = 19'h1 << 12, RT = 19'h1 << 13, AS = 19'h1 << 14;

    function automatic logic [18:0] alu(input int code);
        return 19'(code) << 15;
    endfunction

    function automatic logic [18:0] refDecode(input logic [5:0] op, input logic [5:0] fn);
        logic [18:0] r;
        r = RT | RD;
        if (op == 6'h00) begin
            case (fn)
                6'h20: return alu(0)   | r | RW;
                6'h22: return alu(1)   | r | RW;
                6'h24: return alu(4)   | r | RW;
                6'h25: return alu(5)   | r | RW;
                6'h26: return alu(6)   | r | RW;
                6'h04: return alu(9)   | r | RW;
                6'h00: return alu(9)   | r | RW | SH;
                6'h06: return alu(10)  | r | RW;
                6'h07: return alu(11)  | r | RW;
                6'h1A: return alu(3)   | r | DS;
                6'h10: return alu(15)  | r | RW | MH;
                6'h12: return alu(15)  | r | RW | ML;
                6'h08: return alu(15)  | r | JR;
                default: return IL;
            endcase
        end
        case (op)
            6'h08: return alu(12) | AS | RW;
            6'h0A: return alu(2)  | AS | RW;
            6'h23: return alu(0)  | AS | MR | MT | RW;
            6'h2B: return alu(0)  | AS | MW;
            6'h05: return alu(7)  | AS | BR;
            6'h02: return alu(15) | JJ;
            default: return IL;
        endcase
    endfunction

    function automatic bit isDep(input logic [5:0] op, input logic [5:0] fn);
        return op == 6'h00 && (fn == 6'h1A || fn == 6'h10 || fn == 6'h12);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive, check handshake, clock, check registered results.
    task automatic step(input bit rst, input bit vld, input logic [5:0] op,
                        input logic [5:0] fn, input bit done, output bit acc);
        bit busyNow, expReady;
        logic [18:0] expCtrl;
        reset = rst; inst_valid = vld; opCode = op; func = fn; divDone = done;
        #1;
        busyNow  = (cyc >= busyStart) && (cyc <= busyEnd);
        expReady = !(busyNow && isDep(op, fn));
        chk("inst_ready", 32'(inst_ready), 32'(expReady));
        chk("stall", 32'(stall), 32'(vld && !expReady));
        acc     = vld && expReady && !rst;
        expCtrl = acc ? refDecode(op, fn) : '0;
        if (HAS_DONE && done && busyNow) busyEnd = cyc;
        if (acc && op == 6'h00 && fn == 6'h1A) begin
            busyStart = cyc + 1;
            busyEnd   = cyc + LAT;
        end
        if (rst) begin
            busyStart = 1;
            busyEnd   = 0;
        end
        @(posedge main_clock);
        #1;
        cyc++;
        chk("ctrl_valid", 32'(ctrl_valid), 32'(acc));
        chk("controls", 32'(obsCtrl), 32'(expCtrl));
        chk("div_busy", 32'(div_busy), 32'((cyc >= busyStart) && (cyc <= busyEnd)));
    endtask

    initial begin : main
        bit acc, got;
        int tDiv, stalls;
        logic [5:0] opPool [10];
        logic [5:0] fnPool [15];
        opPool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0A, 6'h23, 6'h2B, 6'h05, 6'h02, 6'h3F};
        fnPool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h04, 6'h00, 6'h06,
                   6'h07, 6'h1A, 6'h10, 6'h12, 6'h08, 6'h3F, 6'h01};

        // reset state
        repeat (2) @(posedge main_clock);
        #1;
        chk("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
        chk("rst_controls", 32'(obsCtrl), 32'd0);
        chk("rst_div_busy", 32'(div_busy), 32'd0);
        chk("rst_inst_ready", 32'(inst_ready), 32'd1);
        reset = 1'b0;

        // add, then idle
        step(0, 1, 6'h00, 6'h20, 0, acc);
        step(0, 0, 6'h00, 6'h20, 0, acc);
        // lw, sw, bne, j back-to-back
        step(0, 1, 6'h23, 6'h00, 0, acc);
        step(0, 1, 6'h2B, 6'h00, 0, acc);
        step(0, 1, 6'h05, 6'h00, 0, acc);
        step(0, 1, 6'h02, 6'h00, 0, acc);

        // div then mfhi held until accepted
        tDiv = cyc;
        step(0, 1, 6'h00, 6'h1A, 0, acc);
        got = 0; stalls = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            step(0, 1, 6'h00, 6'h10, 0, acc);
            if (acc) got = 1; else stalls++;
        end
        chk("mfhi_accepted", 32'(got), 32'd1);
        chk("mfhi_stall_cycles", 32'(stalls), 32'(LAT));
        chk("mfhi_accept_cycle", 32'(cyc - 1), 32'(tDiv + LAT + 1));

        // independent addi issues under a divide
        step(0, 1, 6'h00, 6'h1A, 0, acc);
        step(0, 1, 6'h08, 6'h00, 0, acc);
        chk("addi_during_busy", 32'({div_busy, ALUop}), 32'h1C);
        repeat (LAT) step(0, 0, 6'h00, 6'h00, 0, acc);

        // reset in the middle of a divide releases a pending mfhi
        step(0, 1, 6'h00, 6'h1A, 0, acc);
        step(0, 1, 6'h00, 6'h10, 0, acc);
        step(1, 1, 6'h00, 6'h10, 0, acc);
        step(0, 1, 6'h00, 6'h10, 0, acc);
        chk("mfhi_after_reset", 32'(acc), 32'd1);

        // illegal opcode and illegal R-type function
        step(0, 1, 6'h3F, 6'h00, 0, acc);
        step(0, 1, 6'h00, 6'h3F, 0, acc);
        step(0, 1, 6'h00, 6'h00, 0, acc);
        step(0, 1, 6'h00, 6'h08, 0, acc);

`ifdef DIV_DONE_EN
        // early completion: done at t+2 -> idle at t+3
        step(0, 1, 6'h00, 6'h1A, 0, acc);
        step(0, 0, 6'h00, 6'h00, 0, acc);
        step(0, 0, 6'h00, 6'h00, 1, acc);
        chk("early_done", 32'(div_busy), 32'd0);
`endif

        // random stream
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                 opPool[$urandom_range(0, 9)], fnPool[$urandom_range(0, 14)],
                 HAS_DONE && ($urandom_range(0, 7) == 0), acc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
